// File: rtl/cdc_fifo_pkg.sv
// Shared helpers for both halves of the gray-pointer asynchronous FIFO.
// Pointers up to 32 bits wide are handled; callers zero-extend in and size-cast out.
package cdc_fifo_pkg;

    localparam int MaxPtrWidth = 32;

    function automatic logic [MaxPtrWidth-1:0] bin2gray(input logic [MaxPtrWidth-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [MaxPtrWidth-1:0] gray2bin(input logic [MaxPtrWidth-1:0] gray);
        logic [MaxPtrWidth-1:0] bin;
        bin = gray;
        for (int i = 1; i < MaxPtrWidth; i++) begin
            bin = bin ^ (gray >> i);
        end
        return bin;
    endfunction

    // Width of the flattened storage bus crossing between the two halves.
    function automatic int flat_data_width(input int data_width, input int log_depth);
        return data_width * (1 << log_depth);
    endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// Multi-flop synchroniser for a gray-coded FIFO pointer; shared by both FIFO halves.
module gray_ptr_sync #(
    parameter int Width  = 4,
    parameter int Stages = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] async_i,
    output logic [Width-1:0] sync_o
);

    logic [Width-1:0] stage_q [Stages];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < Stages; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= async_i;
            for (int i = 1; i < Stages; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign sync_o = stage_q[Stages-1];

endmodule

// File: rtl/cdc_fifo_dst_channel.sv
// Read half of a gray-pointer async FIFO: syncs the write pointer, pops entries
// from the foreign storage bus into a valid/ready output register.
module cdc_fifo_dst_channel
    import cdc_fifo_pkg::*;
#(
    parameter int DataWidth  = 64,
    parameter int LogDepth   = 3,
    parameter int SyncStages = 3
) (
    input  logic                                              clk_i,
    input  logic                                              rst_i,
    input  logic [flat_data_width(DataWidth, LogDepth)-1:0]   async_data_i,
    input  logic [LogDepth:0]                                 async_wptr_i,
    output logic [LogDepth:0]                                 async_rptr_o,
    output logic [DataWidth-1:0]                              dst_data_o,
    output logic                                              dst_valid_o,
    input  logic                                              dst_ready_i,
    output logic [LogDepth:0]                                 fill_o,
    output logic                                              err_o
);

    localparam int PtrW = LogDepth + 1;
    localparam logic [PtrW-1:0] Depth = PtrW'(1 << LogDepth);

    logic [PtrW-1:0]      wptr_sync, wptr_bin;
    logic [PtrW-1:0]      rptr_bin, rptr_gray_q, rptr_next;
    logic [PtrW-1:0]      fill;
    logic [DataWidth-1:0] head_entry, out_data_q;
    logic                 out_valid_q, err_q;
    logic                 empty, load;

    gray_ptr_sync #(
        .Width  (PtrW),
        .Stages (SyncStages)
    ) u_wptr_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (async_wptr_i),
        .sync_o  (wptr_sync)
    );

    assign wptr_bin  = PtrW'(gray2bin(MaxPtrWidth'(wptr_sync)));
    assign rptr_next = rptr_bin + 1'b1;
    assign empty     = (wptr_sync == rptr_gray_q);
    assign load      = !empty && (!out_valid_q || dst_ready_i);
    assign fill      = wptr_bin - rptr_bin;

    // The addressed slot is stable once its write is visible through the synced pointer.
    assign head_entry = async_data_i[int'(rptr_bin[LogDepth-1:0]) * DataWidth +: DataWidth];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rptr_bin    <= '0;
            rptr_gray_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            if (load) begin
                out_data_q  <= head_entry;
                out_valid_q <= 1'b1;
                rptr_bin    <= rptr_next;
                rptr_gray_q <= PtrW'(bin2gray(MaxPtrWidth'(rptr_next)));
            end else if (dst_ready_i && out_valid_q) begin
                out_valid_q <= 1'b0;
            end
            if (fill > Depth) begin
                err_q <= 1'b1;
            end
        end
    end

    assign async_rptr_o = rptr_gray_q;
    assign dst_data_o   = out_data_q;
    assign dst_valid_o  = out_valid_q;
    assign fill_o       = fill;
    assign err_o        = err_q;

endmodule

// File: tb/tb_cdc_fifo_dst_channel.sv
// Directed bench for the read half of the async FIFO channel.
module tb_cdc_fifo_dst_channel;

    localparam int DW = 64;
    localparam int LD = 3;
    localparam int SS = 3;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic [DW*8-1:0] async_data_i;
    logic [3:0]     async_wptr_i;
    logic [3:0]     async_rptr_o;
    logic [DW-1:0]  dst_data_o;
    logic           dst_valid_o;
    logic           dst_ready_i;
    logic [3:0]     fill_o;
    logic           err_o;

    int n_checks = 0;
    int n_pass   = 0;

    cdc_fifo_dst_channel #(
        .DataWidth  (DW),
        .LogDepth   (LD),
        .SyncStages (SS)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .async_data_i (async_data_i),
        .async_wptr_i (async_wptr_i),
        .async_rptr_o (async_rptr_o),
        .dst_data_o   (dst_data_o),
        .dst_valid_o  (dst_valid_o),
        .dst_ready_i  (dst_ready_i),
        .fill_o       (fill_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    function automatic logic [3:0] gray(input int b);
        logic [3:0] v;
        v = 4'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic set_entry(input int slot, input logic [63:0] v);
        async_data_i[slot*DW +: DW] = v;
    endtask

    task automatic do_reset();
        rst_i        = 1'b1;
        async_wptr_i = '0;
        dst_ready_i  = 1'b0;
        step(2);
        rst_i = 1'b0;
    endtask

    // Consume with ready held high until `target` entries have been seen.
    task automatic drain(input int first, input int target);
        int cnt    = first;
        int budget = 100;
        while (cnt < target && budget > 0) begin
            if (dst_valid_o) begin
                check("wrap_data", dst_data_o, 64'h3000 + 64'(cnt));
                check("wrap_rptr", 64'(async_rptr_o), 64'(gray((cnt + 1) % 16)));
                cnt++;
            end
            if (cnt < target) step();
            budget--;
        end
        if (budget == 0) check("wrap_timeout", 64'(cnt), 64'(target));
    endtask

    initial begin
        logic [63:0] exp_bp [4];
        logic [63:0] held;
        logic        stalled;
        int          idx;
        int          budget;

        async_data_i = '0;
        dst_ready_i  = 1'b0;

        // Reset state
        do_reset();
        check("rst_rptr",  64'(async_rptr_o), 64'd0);
        check("rst_valid", 64'(dst_valid_o),  64'd0);
        check("rst_fill",  64'(fill_o),       64'd0);
        check("rst_err",   64'(err_o),        64'd0);
        check("rst_data",  dst_data_o,        64'd0);

        // Single entry: visible after SyncStages+1 edges
        set_entry(0, 64'hA5);
        dst_ready_i  = 1'b1;
        async_wptr_i = gray(1);
        step(3);
        check("single_valid_e3", 64'(dst_valid_o), 64'd0);
        check("single_fill_e3",  64'(fill_o),      64'd1);
        step();
        check("single_valid_e4", 64'(dst_valid_o), 64'd1);
        check("single_data",     dst_data_o,       64'hA5);
        check("single_rptr",     64'(async_rptr_o), 64'(gray(1)));
        check("single_fill_e4",  64'(fill_o),      64'd0);
        step();
        check("single_valid_e5", 64'(dst_valid_o), 64'd0);

        // Full FIFO, stalled then drained back-to-back
        do_reset();
        for (int k = 0; k < 8; k++) set_entry(k, 64'h1000 + 64'(k));
        async_wptr_i = 4'b1100;
        step(4);
        check("full_valid", 64'(dst_valid_o), 64'd1);
        check("full_head",  dst_data_o,       64'h1000);
        check("full_fill",  64'(fill_o),      64'd7);
        step(2);
        check("full_hold",  dst_data_o,       64'h1000);
        check("full_fill2", 64'(fill_o),      64'd7);
        dst_ready_i = 1'b1;
        for (int k = 1; k < 8; k++) begin
            step();
            check("full_valid_k", 64'(dst_valid_o), 64'd1);
            check("full_data_k",  dst_data_o,       64'h1000 + 64'(k));
        end
        check("full_rptr_end", 64'(async_rptr_o), 64'b1100);
        check("full_fill_end", 64'(fill_o),       64'd0);
        step();
        check("full_empty", 64'(dst_valid_o), 64'd0);

        // Backpressure: ready 1,0,1,0...
        do_reset();
        exp_bp = '{64'hBEEF_0001, 64'hBEEF_0002, 64'hBEEF_0003, 64'hBEEF_0004};
        for (int k = 0; k < 4; k++) set_entry(k, exp_bp[k]);
        async_wptr_i = gray(4);
        budget = 10;
        while (!dst_valid_o && budget > 0) begin
            step();
            budget--;
        end
        check("bp_first_valid", 64'(dst_valid_o), 64'd1);
        idx     = 0;
        stalled = 1'b0;
        held    = '0;
        for (int i = 0; i < 12; i++) begin
            dst_ready_i = (i % 2 == 0);
            if (stalled) check("bp_hold", dst_data_o, held);
            if (dst_valid_o && dst_ready_i) begin
                if (idx < 4) check("bp_data", dst_data_o, exp_bp[idx]);
                idx++;
            end
            stalled = dst_valid_o && !dst_ready_i;
            held    = dst_data_o;
            step();
        end
        check("bp_count", 64'(idx), 64'd4);
        check("bp_drained", 64'(dst_valid_o), 64'd0);

        // Wrap: 20 entries written in batches, pointer rolls past 15
        do_reset();
        dst_ready_i = 1'b1;
        for (int n = 0; n < 8; n++) set_entry(n % 8, 64'h3000 + 64'(n));
        async_wptr_i = gray(8);
        drain(0, 8);
        step(2);
        for (int n = 8; n < 16; n++) set_entry(n % 8, 64'h3000 + 64'(n));
        async_wptr_i = gray(0);
        drain(8, 16);
        step(2);
        for (int n = 16; n < 20; n++) set_entry(n % 8, 64'h3000 + 64'(n));
        async_wptr_i = gray(4);
        drain(16, 20);
        step(2);
        check("wrap_empty", 64'(dst_valid_o), 64'd0);
        check("wrap_err",   64'(err_o),       64'd0);

        // Protocol error: write pointer nine ahead of read pointer
        do_reset();
        async_wptr_i = 4'b1101;
        step(4);
        check("err_set", 64'(err_o), 64'd1);
        async_wptr_i = gray(1);
        step(6);
        check("err_sticky", 64'(err_o), 64'd1);
        do_reset();
        check("err_cleared", 64'(err_o), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
